eh2_lsu_bus_clken_gen: RTL and testbench



---
 rtl/eh2_pkg.sv | 13 +
 rtl/eh2_lsu_bus_halt_sync.sv | 53 +++++
 rtl/eh2_lsu_bus_clken_gen.sv | 74 +++++++
 tb/tb_eh2_lsu_bus_clken_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared LSU bus-side types: halt-handshake states and the core:bus ratio width.
package eh2_pkg;

  localparam int EH2_BUS_RATIO_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ASSERT = 2'd2,
    DONE   = 2'd3
  } eh2_bus_halt_state_t;

endpackage

// File: rtl/eh2_lsu_bus_halt_sync.sv
// Single-thread force-halt handshake aligned to bus edges.
// Latency: force_halt_bus rises one cycle after the first bus edge following a halt rise.
// Backpressure: none; waits on buffer_empty at bus edges before signalling done.
module eh2_lsu_bus_halt_sync
  import eh2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic force_halt,
  input  logic bus_clk_en,
  input  logic buffer_empty,
  output logic force_halt_bus,
  output logic force_halt_done
);

  eh2_bus_halt_state_t state, state_nxt;
  logic fh_q;
  logic rise;
  logic done_nxt;

  assign rise = force_halt & ~fh_q;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:   if (rise) state_nxt = PEND;
      PEND:   if (bus_clk_en) state_nxt = ASSERT;
      ASSERT: if (bus_clk_en && buffer_empty) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE:   if (bus_clk_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Halt level is registered off the next state so it only moves right after a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fh_q            <= 1'b0;
      force_halt_bus  <= 1'b0;
      force_halt_done <= 1'b0;
    end else begin
      state           <= state_nxt;
      fh_q            <= force_halt;
      force_halt_bus  <= (state_nxt == ASSERT) || (state_nxt == DONE);
      force_halt_done <= done_nxt;
    end
  end

endmodule

// File: rtl/eh2_lsu_bus_clken_gen.sv
// Core-to-bus clock-enable generator with boundary-aligned ratio changes and per-thread halt sync.
// Latency: enable registered; first pulse ratio+1 cycles after reset; ratio changes land on a wrap.
// Backpressure: none; free-running, ratio_busy flags a not-yet-applied ratio.
module eh2_lsu_bus_clken_gen
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int RATIO_W     = EH2_BUS_RATIO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATIO_W-1:0]     bus_ratio,
  input  logic                   ratio_update,
  input  logic [NUM_THREADS-1:0] dec_tlu_force_halt,
  input  logic [NUM_THREADS-1:0] lsu_bus_buffer_empty_any,
  output logic                   lsu_bus_clk_en,
  output logic                   ratio_busy,
  output logic [NUM_THREADS-1:0] dec_tlu_force_halt_bus,
  output logic [NUM_THREADS-1:0] force_halt_done
);

  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] ratio_cur;
  logic [RATIO_W-1:0] ratio_pend;
  logic               pend_vld;
  logic               wrap;

  assign wrap       = (cnt == ratio_cur);
  assign ratio_busy = pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      lsu_bus_clk_en <= 1'b0;
    end else if (wrap) begin
      cnt            <= '0;
      lsu_bus_clk_en <= 1'b1;
    end else begin
      cnt            <= cnt + RATIO_W'(1);
      lsu_bus_clk_en <= 1'b0;
    end
  end

  // A capture in a wrap cycle wins over the clear, so it waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_cur  <= '0;
      ratio_pend <= '0;
      pend_vld   <= 1'b0;
    end else begin
      if (wrap && pend_vld) begin
        ratio_cur <= ratio_pend;
        pend_vld  <= 1'b0;
      end
      if (ratio_update) begin
        ratio_pend <= bus_ratio;
        pend_vld   <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    eh2_lsu_bus_halt_sync u_halt_sync (
      .clk             (clk),
      .rst             (rst),
      .force_halt      (dec_tlu_force_halt[i]),
      .bus_clk_en      (lsu_bus_clk_en),
      .buffer_empty    (lsu_bus_buffer_empty_any[i]),
      .force_halt_bus  (dec_tlu_force_halt_bus[i]),
      .force_halt_done (force_halt_done[i])
    );
  end

endmodule

// File: tb/tb_eh2_lsu_bus_clken_gen.sv
// Bench for eh2_lsu_bus_clken_gen: directed scenarios then random traffic against an
// event-time reference model (absolute bus-edge schedule plus per-thread halt progress).
module tb_eh2_lsu_bus_clken_gen;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    bus_ratio = '0;
  logic          ratio_update = 1'b0;
  logic [NT-1:0] dec_tlu_force_halt = '0;
  logic [NT-1:0] lsu_bus_buffer_empty_any = '0;
  logic          lsu_bus_clk_en;
  logic          ratio_busy;
  logic [NT-1:0] dec_tlu_force_halt_bus;
  logic [NT-1:0] force_halt_done;

  eh2_lsu_bus_clken_gen #(.NUM_THREADS(NT), .RATIO_W(3)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .bus_ratio                (bus_ratio),
    .ratio_update             (ratio_update),
    .dec_tlu_force_halt       (dec_tlu_force_halt),
    .lsu_bus_buffer_empty_any (lsu_bus_buffer_empty_any),
    .lsu_bus_clk_en           (lsu_bus_clk_en),
    .ratio_busy               (ratio_busy),
    .dec_tlu_force_halt_bus   (dec_tlu_force_halt_bus),
    .force_halt_done          (force_halt_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bus edges scheduled as absolute cycle numbers.
  int            cyc;
  int            wrap_at;
  int            per;
  bit            pvld;
  int            pend;
  bit [NT-1:0]   prev_fh;
  bit [NT-1:0]   active;
  int            edges [NT];
  bit            e_en;
  bit            e_busy;
  bit [NT-1:0]   e_fhb;
  bit [NT-1:0]   e_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; wrap_at = 0; per = 1; pvld = 0; pend = 0;
    prev_fh = '0; active = '0;
    for (int i = 0; i < NT; i++) edges[i] = 0;
    e_en = 0; e_busy = 0; e_fhb = '0; e_done = '0;
  endtask

  task automatic check_outputs();
    chk("clk_en", 32'(lsu_bus_clk_en), 32'(e_en));
    chk("ratio_busy", 32'(ratio_busy), 32'(e_busy));
    chk("fh_bus", 32'(dec_tlu_force_halt_bus), 32'(e_fhb));
    chk("fh_done", 32'(force_halt_done), 32'(e_done));
  endtask

  // Called at a negedge: check, drive inputs for the coming edge, advance the model.
  task automatic step(input bit upd, input bit [2:0] r, input bit [NT-1:0] fh, input bit [NT-1:0] emp);
    bit wrap;
    check_outputs();
    ratio_update = upd;
    bus_ratio = r;
    dec_tlu_force_halt = fh;
    lsu_bus_buffer_empty_any = emp;
    wrap = (cyc == wrap_at);
    for (int i = 0; i < NT; i++) begin
      e_done[i] = 0;
      if (active[i]) begin
        if (e_en) begin
          if (edges[i] == 0) edges[i] = 1;
          else if (edges[i] == 1 && emp[i]) begin edges[i] = 2; e_done[i] = 1; end
          else if (edges[i] == 2) active[i] = 0;
        end
      end else if (fh[i] && !prev_fh[i]) begin
        active[i] = 1;
        edges[i] = 0;
      end
      e_fhb[i] = active[i] && (edges[i] >= 1);
    end
    prev_fh = fh;
    if (wrap) begin
      if (pvld) begin per = pend + 1; pvld = 0; end
      wrap_at = cyc + per;
    end
    if (upd) begin pend = int'(r); pvld = 1; end
    e_en = wrap;
    e_busy = pvld;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit [NT-1:0] fh, input bit [NT-1:0] emp);
    for (int j = 0; j < n; j++) step(0, 3'd0, fh, emp);
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ratio 0 then 3.
    idle(4, 2'b00, 2'b11);
    step(1, 3'd3, 2'b00, 2'b11);
    idle(12, 2'b00, 2'b11);

    // Update landing exactly in a wrap cycle.
    while (cyc != wrap_at) step(0, 3'd0, 2'b00, 2'b11);
    step(1, 3'd1, 2'b00, 2'b11);
    idle(12, 2'b00, 2'b11);

    // Back-to-back updates: last value wins.
    step(1, 3'd1, 2'b00, 2'b11);
    step(1, 3'd5, 2'b00, 2'b11);
    idle(20, 2'b00, 2'b11);
    step(1, 3'd3, 2'b00, 2'b11);
    idle(12, 2'b00, 2'b11);

    // Thread0 halt with buffer already empty.
    idle(20, 2'b01, 2'b11);
    idle(4, 2'b00, 2'b11);

    // Thread1 halt with buffer busy for several bus periods.
    idle(14, 2'b10, 2'b01);
    idle(12, 2'b10, 2'b11);
    idle(4, 2'b00, 2'b11);

    // Second rise while the sequence is in flight, and a drop mid-sequence.
    idle(3, 2'b01, 2'b00);
    idle(1, 2'b00, 2'b00);
    idle(6, 2'b01, 2'b00);
    idle(12, 2'b01, 2'b11);
    idle(4, 2'b00, 2'b11);

    // Reset while in ASSERT with a ratio change pending.
    idle(6, 2'b01, 2'b00);
    step(1, 3'd5, 2'b01, 2'b00);
    #2;
    rst = 1'b1;
    ratio_update = 1'b0;
    dec_tlu_force_halt = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    idle(10, 2'b00, 2'b11);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit [NT-1:0] fh;
      bit [NT-1:0] emp;
      for (int i = 0; i < NT; i++) begin
        fh[i]  = ($urandom_range(0, 7) == 0) ? ~dec_tlu_force_halt[i] : dec_tlu_force_halt[i];
        emp[i] = ($urandom_range(0, 2) != 0);
      end
      step($urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), fh, emp);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
